// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial Y86-style instruction fetch with opcode/register/constant decode
// One memory byte per ack; decoded fields are presented to decode in HOLD until accepted.
module fetch_unit #(
   parameter int unsigned IMEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_load,
   input  logic [63:0] pc_new,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [1:0]  stat
);
   typedef enum logic [2:0] {S_IDLE, S_OPC, S_REGS, S_CONST, S_HOLD, S_STOP} state_t;

   localparam logic [1:0]  ST_AOK = 2'd0;
   localparam logic [1:0]  ST_HLT = 2'd1;
   localparam logic [1:0]  ST_ADR = 2'd2;
   localparam logic [1:0]  ST_INS = 2'd3;
   localparam logic [63:0] LIMIT  = 64'(IMEM_SIZE);

   state_t      r_state;
   logic [63:0] r_pc;
   logic [63:0] r_mem_addr;
   logic        r_mem_req;
   logic        r_out_valid;
   logic [3:0]  r_icode;
   logic [3:0]  r_ifun;
   logic [3:0]  r_ra;
   logic [3:0]  r_rb;
   logic [63:0] r_valc;
   logic [63:0] r_valp;
   logic [1:0]  r_stat;
   logic [2:0]  r_cnt;

   logic        w_accept;
   logic        w_restart;
   logic [63:0] w_start_pc;
   logic        w_start_oor;
   logic [63:0] w_next_addr;
   logic        w_next_oor;
   logic [3:0]  w_op;
   logic [3:0]  w_len;
   logic        w_op_reg;
   logic        w_cur_const;

   function automatic logic [3:0] instr_len(input logic [3:0] ic);
      case (ic)
         4'd2, 4'd6, 4'd10, 4'd11: instr_len = 4'd2;
         4'd7, 4'd8:               instr_len = 4'd9;
         4'd3, 4'd4, 4'd5:         instr_len = 4'd10;
         default:                  instr_len = 4'd1;
      endcase
   endfunction

   assign w_accept    = (r_state == S_HOLD) && out_ready;
   assign w_restart   = pc_load || (w_accept && (r_stat == ST_AOK));
   assign w_start_pc  = pc_load ? pc_new : r_valp;
   assign w_start_oor = (w_start_pc >= LIMIT);
   assign w_next_addr = r_mem_addr + 64'd1;
   assign w_next_oor  = (w_next_addr >= LIMIT);
   assign w_op        = mem_rdata[7:4];
   assign w_len       = instr_len(w_op);
   assign w_op_reg    = (w_len == 4'd2) || (w_len == 4'd10);
   assign w_cur_const = (instr_len(r_icode) >= 4'd9);

   // A fetch state entered with mem_req low means its byte address was out of range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= 64'd0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= 64'd0;
         r_out_valid <= 1'b0;
         r_icode     <= 4'd0;
         r_ifun      <= 4'd0;
         r_ra        <= 4'hF;
         r_rb        <= 4'hF;
         r_valc      <= 64'd0;
         r_valp      <= 64'd0;
         r_stat      <= ST_AOK;
         r_cnt       <= 3'd0;
      end else if (w_restart) begin
         r_state     <= S_OPC;
         r_pc        <= w_start_pc;
         r_mem_req   <= !w_start_oor;
         if (!w_start_oor)
            r_mem_addr <= w_start_pc;
         r_out_valid <= 1'b0;
         r_icode     <= 4'd0;
         r_ifun      <= 4'd0;
         r_ra        <= 4'hF;
         r_rb        <= 4'hF;
         r_valc      <= 64'd0;
         r_valp      <= w_start_pc;
         r_stat      <= ST_AOK;
         r_cnt       <= 3'd0;
      end else if (w_accept) begin
         r_state     <= S_STOP;
         r_pc        <= r_valp;
         r_mem_req   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_OPC, S_REGS, S_CONST: begin
               if (!r_mem_req) begin
                  r_state     <= S_HOLD;
                  r_out_valid <= 1'b1;
                  r_stat      <= ST_ADR;
               end else if (mem_ack) begin
                  if (r_state == S_OPC) begin
                     r_icode <= w_op;
                     r_ifun  <= mem_rdata[3:0];
                     r_valp  <= r_pc + {60'd0, w_len};
                     r_stat  <= (w_op == 4'd0) ? ST_HLT : ((w_op > 4'd11) ? ST_INS : ST_AOK);
                  end else if (r_state == S_REGS) begin
                     r_ra <= mem_rdata[7:4];
                     r_rb <= mem_rdata[3:0];
                  end else begin
                     r_valc[{r_cnt, 3'b000} +: 8] <= mem_rdata;
                     r_cnt <= r_cnt + 3'd1;
                  end

                  if ((r_state == S_OPC && w_len == 4'd1) ||
                      (r_state == S_REGS && !w_cur_const) ||
                      (r_state == S_CONST && r_cnt == 3'd7)) begin
                     r_state     <= S_HOLD;
                     r_mem_req   <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     if (r_state == S_OPC)
                        r_state <= w_op_reg ? S_REGS : S_CONST;
                     else
                        r_state <= S_CONST;
                     r_mem_req <= !w_next_oor;
                     if (!w_next_oor)
                        r_mem_addr <= w_next_addr;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign out_valid = r_out_valid;
   assign icode     = r_icode;
   assign ifun      = r_ifun;
   assign rA        = r_ra;
   assign rB        = r_rb;
   assign valC      = r_valc;
   assign valP      = r_valp;
   assign stat      = r_stat;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench: directed cases plus random programs against a byte-level model
module tb_fetch_unit;
   localparam int          IMEM   = 512;
   localparam int          AW     = 9;
   localparam logic [63:0] IMEM64 = 64'(IMEM);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_load;
   logic [63:0] pc_new;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic [1:0]  stat;

   always #5 clk = ~clk;

   fetch_unit #(.IMEM_SIZE(IMEM)) dut (
      .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_new(pc_new),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .stat(stat)
   );

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic [1:0]  stat;
   } exp_t;

   logic [7:0]  mem [IMEM];
   int          n_checks = 0;
   int          n_errors = 0;
   int          proto_err = 0;
   int          ack_mode = 1;
   logic        prev_req, prev_ack, prev_load;
   logic [63:0] prev_addr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rand_byte();
      return {4'($urandom_range(0, 13)), 4'($urandom)};
   endfunction

   // Expected decode of the instruction at pc, straight from the length/field rules.
   function automatic exp_t model(input logic [63:0] pc);
      exp_t        e;
      int          len;
      bit          has_reg;
      logic [63:0] a;
      logic [7:0]  b;
      e = '{icode:4'h0, ifun:4'h0, ra:4'hF, rb:4'hF, valc:64'd0, valp:pc, stat:2'd0};
      if (pc >= IMEM64) begin
         e.stat = 2'd2;
         return e;
      end
      b = mem[pc[AW-1:0]];
      e.icode = b[7:4];
      e.ifun  = b[3:0];
      case (int'(b[7:4]))
         2, 6, 10, 11: len = 2;
         7, 8:         len = 9;
         3, 4, 5:      len = 10;
         default:      len = 1;
      endcase
      e.valp  = pc + 64'(len);
      e.stat  = (b[7:4] == 4'd0) ? 2'd1 : ((b[7:4] > 4'd11) ? 2'd3 : 2'd0);
      has_reg = (len == 2) || (len == 10);
      for (int i = 1; i < len; i++) begin
         a = pc + 64'(i);
         if (a >= IMEM64) begin
            e.stat = 2'd2;
            return e;
         end
         if (has_reg && i == 1) begin
            e.ra = mem[a[AW-1:0]][7:4];
            e.rb = mem[a[AW-1:0]][3:0];
         end else begin
            e.valc[8*(i - (has_reg ? 2 : 1)) +: 8] = mem[a[AW-1:0]];
         end
      end
      return e;
   endfunction

   task automatic check_fields(input string tag, input exp_t e);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_icode"}, 64'(icode), 64'(e.icode));
      chk({tag, "_ifun"},  64'(ifun),  64'(e.ifun));
      chk({tag, "_rA"},    64'(rA),    64'(e.ra));
      chk({tag, "_rB"},    64'(rB),    64'(e.rb));
      chk({tag, "_valC"},  valC,       e.valc);
      chk({tag, "_valP"},  valP,       e.valp);
      chk({tag, "_stat"},  64'(stat),  64'(e.stat));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_mem_req"},   64'(mem_req),   64'd0);
      chk({tag, "_mem_addr"},  mem_addr,       64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_icode"},     64'(icode),     64'd0);
      chk({tag, "_ifun"},      64'(ifun),      64'd0);
      chk({tag, "_rA"},        64'(rA),        64'hF);
      chk({tag, "_rB"},        64'(rB),        64'hF);
      chk({tag, "_valC"},      valC,           64'd0);
      chk({tag, "_valP"},      valP,           64'd0);
      chk({tag, "_stat"},      64'(stat),      64'd0);
   endtask

   task automatic start(input logic [63:0] pc);
      pc_load = 1'b1;
      pc_new  = pc;
      @(negedge clk);
      pc_load = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      if (!out_valid)
         chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // Memory model: answers requests, watches request stability and address range.
   always @(posedge clk) prev_load <= pc_load || !rst_n;

   always @(negedge clk) begin
      if (prev_req === 1'b1 && prev_ack === 1'b0 && prev_load === 1'b0 &&
          (!mem_req || mem_addr != prev_addr))
         proto_err++;
      if (mem_req && mem_addr >= IMEM64)
         proto_err++;
      case (ack_mode)
         1:       mem_ack = mem_req;
         0:       mem_ack = mem_req && ($urandom_range(0, 2) != 0);
         default: mem_ack = 1'b0;
      endcase
      mem_rdata = (mem_addr < IMEM64) ? mem[mem_addr[AW-1:0]] : 8'h00;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      prev_ack  = mem_ack;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      exp_t        e;
      int          cyc;
      logic [63:0] pc;
      rst_n = 1'b0; pc_load = 1'b0; pc_new = 64'd0; out_ready = 1'b0; ack_mode = 1;
      for (int i = 0; i < IMEM; i++) mem[i] = rand_byte();
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_req", 64'(mem_req), 64'd0);

      mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
      for (int i = 3; i < 10; i++) mem[i] = 8'h00;
      start(64'd0);
      wait_valid("irmov", cyc);
      chk("irmov_latency", 64'(cyc), 64'd10);
      check_fields("irmov", '{icode:4'h3, ifun:4'h0, ra:4'hF, rb:4'h3, valc:64'd10, valp:64'd10, stat:2'd0});

      mem[32] = 8'h60; mem[33] = 8'h12;
      start(64'h20);
      chk("hold_abort_valid", 64'(out_valid), 64'd0);
      wait_valid("opq", cyc);
      repeat (5) begin
         check_fields("opq_hold", '{icode:4'h6, ifun:4'h0, ra:4'h1, rb:4'h2, valc:64'd0, valp:64'h22, stat:2'd0});
         @(negedge clk);
      end
      accept();
      chk("opq_next_req", 64'(mem_req), 64'd1);
      chk("opq_next_addr", mem_addr, 64'h22);

      mem[64] = 8'h00;
      start(64'h40);
      wait_valid("halt", cyc);
      chk("halt_stat", 64'(stat), 64'd1);
      chk("halt_valP", valP, 64'h41);
      accept();
      repeat (4) begin
         chk("stop_req", 64'(mem_req), 64'd0);
         chk("stop_valid", 64'(out_valid), 64'd0);
         @(negedge clk);
      end

      mem[IMEM-4] = 8'h70;
      start(IMEM64 - 64'd4);
      wait_valid("adr", cyc);
      chk("adr_stat", 64'(stat), 64'd2);
      check_fields("adr", model(IMEM64 - 64'd4));
      chk("adr_no_oor_req", 64'(proto_err), 64'd0);

      mem[128] = 8'hF0;
      start(64'd128);
      wait_valid("ins", cyc);
      chk("ins_stat", 64'(stat), 64'd3);
      chk("ins_valP", valP, 64'd129);

      mem[256] = 8'h70;
      for (int i = 1; i < 9; i++) mem[256+i] = rand_byte();
      start(64'd256);
      repeat (5) @(negedge clk);
      chk("abort_byte4_addr", mem_addr, 64'd261);
      pc_load = 1'b1; pc_new = 64'd32;
      @(negedge clk);
      pc_load = 1'b0;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_req", 64'(mem_req), 64'd1);
      chk("abort_addr", mem_addr, 64'd32);
      wait_valid("abort", cyc);
      check_fields("abort", model(64'd32));

      start(64'd32);
      @(negedge clk);
      chk("regs_addr", mem_addr, 64'd33);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("mid_rst");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_idle", 64'(mem_req), 64'd0);

      ack_mode = 0;
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < IMEM; i++) mem[i] = rand_byte();
         pc = 64'($urandom_range(0, IMEM - 1));
         start(pc);
         for (int k = 0; k < 6; k++) begin
            e = model(pc);
            wait_valid("rnd", cyc);
            check_fields("rnd", e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rnd_hold_valP", valP, e.valp);
            accept();
            if (e.stat != 2'd0) begin
               chk("rnd_stop_req", 64'(mem_req), 64'd0);
               chk("rnd_stop_valid", 64'(out_valid), 64'd0);
               break;
            end
            pc = e.valp;
         end
      end

      ack_mode = 1;
      repeat (2) @(negedge clk);
      chk("mem_protocol", 64'(proto_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
